// File: rtl/audioport_pkg.sv
// Shared types and defaults for the audio port sample path.
package audioport_pkg;

  localparam int unsigned SAMPLE_W         = 24;
  localparam int unsigned MIN_TICK_GAP_DEF = 8;
  localparam int unsigned TIMEOUT_DEF      = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] ch1;
    logic [SAMPLE_W-1:0] ch0;
  } sample_pair_t;

endpackage

// File: rtl/sample_scheduler.sv
// Sequences FIFO samples into the CDC unit: primes on play, answers each request
// with one paced tick, and flags underrun, dropped requests and a stalled mclk.
module sample_scheduler
  import audioport_pkg::*;
#(
  parameter int unsigned MIN_TICK_GAP = MIN_TICK_GAP_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                play_cmd_in,
  input  logic                stop_cmd_in,
  input  logic                clr_in,
  input  logic                fifo_empty_in,
  input  logic [SAMPLE_W-1:0] fifo_data0_in,
  input  logic [SAMPLE_W-1:0] fifo_data1_in,
  output logic                fifo_pop_out,
  input  logic                req_in,
  output logic                tick_out,
  output logic [SAMPLE_W-1:0] audio0_out,
  output logic [SAMPLE_W-1:0] audio1_out,
  output logic                play_out,
  output logic                underrun_out,
  output logic                overrun_out,
  output logic                stall_out,
  output logic [CNT_W-1:0]    underrun_cnt_out
);

  localparam int unsigned GAP_W = (MIN_TICK_GAP > 2) ? $clog2(MIN_TICK_GAP) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_TICK_GAP - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);

  sched_state_t     state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             pending_q, pending_d;
  sample_pair_t     sample_q, sample_d;
  logic             tick_d, pop_d, play_d;
  logic             underrun_d, overrun_d, stall_d;
  logic [CNT_W-1:0] cnt_d;
  logic             issue_c;
  logic             gap_zero_c, wd_zero_c;

  assign gap_zero_c = (gap_q == '0);
  assign wd_zero_c  = (wd_q == '0);
  assign audio0_out = sample_q.ch0;
  assign audio1_out = sample_q.ch1;

  // Next-state, pacing, watchdog and flag logic.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_zero_c ? gap_q : gap_q - GAP_W'(1);
    wd_d       = wd_q;
    pending_d  = pending_q;
    sample_d   = sample_q;
    issue_c    = 1'b0;
    tick_d     = 1'b0;
    pop_d      = 1'b0;
    play_d     = play_out;
    underrun_d = underrun_out & ~clr_in;
    overrun_d  = overrun_out & ~clr_in;
    stall_d    = stall_out & ~clr_in;
    cnt_d      = clr_in ? '0 : underrun_cnt_out;

    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (play_cmd_in && !stop_cmd_in) state_d = PRIME;
      end
      PRIME: begin
        if (stop_cmd_in) begin
          state_d = IDLE;
        end else if (!fifo_empty_in && gap_zero_c) begin
          issue_c = 1'b1;
          play_d  = 1'b1;
          wd_d    = WD_LOAD;
          state_d = RUN;
        end
      end
      RUN: begin
        if (req_in)          wd_d = WD_LOAD;
        else if (!wd_zero_c) wd_d = wd_q - WD_W'(1);
        // A request arriving while the pending one is served refills the slot.
        if (gap_zero_c && (pending_q || req_in)) begin
          issue_c   = 1'b1;
          pending_d = pending_q && req_in;
        end else if (req_in) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (stop_cmd_in) begin
          state_d = STOP;
          play_d  = 1'b0;
        end else if (!req_in && wd_zero_c) begin
          state_d   = IDLE;
          play_d    = 1'b0;
          stall_d   = 1'b1;
          pending_d = 1'b0;
        end
      end
      STOP: begin
        play_d = 1'b0;
        if (gap_zero_c) begin
          if (pending_q) begin
            issue_c   = 1'b1;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue_c) begin
      tick_d = 1'b1;
      gap_d  = GAP_LOAD;
      if (!fifo_empty_in) begin
        pop_d        = 1'b1;
        sample_d.ch0 = fifo_data0_in;
        sample_d.ch1 = fifo_data1_in;
      end else begin
        sample_d   = '0;
        underrun_d = 1'b1;
        if (clr_in)                 cnt_d = CNT_W'(1);
        else if (!(&underrun_cnt_out)) cnt_d = underrun_cnt_out + CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      gap_q            <= '0;
      wd_q             <= '0;
      pending_q        <= 1'b0;
      sample_q         <= '0;
      tick_out         <= 1'b0;
      fifo_pop_out     <= 1'b0;
      play_out         <= 1'b0;
      underrun_out     <= 1'b0;
      overrun_out      <= 1'b0;
      stall_out        <= 1'b0;
      underrun_cnt_out <= '0;
    end else begin
      state_q          <= state_d;
      gap_q            <= gap_d;
      wd_q             <= wd_d;
      pending_q        <= pending_d;
      sample_q         <= sample_d;
      tick_out         <= tick_d;
      fifo_pop_out     <= pop_d;
      play_out         <= play_d;
      underrun_out     <= underrun_d;
      overrun_out      <= overrun_d;
      stall_out        <= stall_d;
      underrun_cnt_out <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: directed scenarios plus random traffic checked
// against a timestamp-based reference model and a queue-backed show-ahead FIFO.
module tb_sample_scheduler;

  localparam int unsigned G  = 8;
  localparam int unsigned T  = 64;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int NUND    = (1 << CW) + 3;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_STOP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          play_cmd_in = 1'b0, stop_cmd_in = 1'b0, clr_in = 1'b0, req_in = 1'b0;
  logic          fifo_empty_in = 1'b1;
  logic [23:0]   fifo_data0_in = '0, fifo_data1_in = '0;
  logic          fifo_pop_out, tick_out, play_out, underrun_out, overrun_out, stall_out;
  logic [23:0]   audio0_out, audio1_out;
  logic [CW-1:0] underrun_cnt_out;

  int total = 0;
  int bad   = 0;

  logic [47:0] fq[$];

  // Reference model state
  int          m_mode;
  bit          m_pend;
  longint      cyc = 0, last_tick, wd_ref;
  int          m_cnt;
  logic        e_tick, e_pop, e_play, e_und, e_ovr, e_stall;
  logic [23:0] e_a0, e_a1;

  logic [54+CW-1:0] obs_vec, exp_vec;
  assign obs_vec = {tick_out, fifo_pop_out, audio0_out, audio1_out, play_out,
                    underrun_out, overrun_out, stall_out, underrun_cnt_out};
  assign exp_vec = {e_tick, e_pop, e_a0, e_a1, e_play, e_und, e_ovr, e_stall, CW'(m_cnt)};

  sample_scheduler #(.MIN_TICK_GAP(G), .TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .play_cmd_in(play_cmd_in), .stop_cmd_in(stop_cmd_in), .clr_in(clr_in),
    .fifo_empty_in(fifo_empty_in), .fifo_data0_in(fifo_data0_in), .fifo_data1_in(fifo_data1_in),
    .fifo_pop_out(fifo_pop_out), .req_in(req_in), .tick_out(tick_out),
    .audio0_out(audio0_out), .audio1_out(audio1_out), .play_out(play_out),
    .underrun_out(underrun_out), .overrun_out(overrun_out), .stall_out(stall_out),
    .underrun_cnt_out(underrun_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic fifo_drive();
    if (fq.size() == 0) begin
      fifo_empty_in = 1'b1;
      fifo_data0_in = 24'hBAD0BA;
      fifo_data1_in = 24'hBAD1BA;
    end else begin
      fifo_empty_in = 1'b0;
      fifo_data0_in = fq[0][23:0];
      fifo_data1_in = fq[0][47:24];
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pend = 0; m_cnt = 0;
    last_tick = cyc - 1000; wd_ref = cyc;
    e_tick = 0; e_pop = 0; e_play = 0; e_und = 0; e_ovr = 0; e_stall = 0;
    e_a0 = '0; e_a1 = '0;
  endtask

  // Spacing and watchdog are tracked as cycle timestamps of the last tick / request.
  task automatic model_edge();
    bit issue, gap_ok, expired;
    cyc++;
    gap_ok  = (cyc - last_tick) >= longint'(G);
    expired = (cyc - wd_ref) >= longint'(T);
    issue = 0; e_tick = 0; e_pop = 0;
    if (clr_in) begin e_und = 0; e_ovr = 0; e_stall = 0; m_cnt = 0; end
    case (m_mode)
      M_IDLE: begin
        m_pend = 0;
        if (play_cmd_in && !stop_cmd_in) m_mode = M_PRIME;
      end
      M_PRIME: begin
        if (stop_cmd_in) m_mode = M_IDLE;
        else if (!fifo_empty_in && gap_ok) begin
          issue = 1; e_play = 1; wd_ref = cyc; m_mode = M_RUN;
        end
      end
      M_RUN: begin
        if (gap_ok && (m_pend || req_in)) begin
          issue = 1; m_pend = m_pend && req_in;
        end else if (req_in) begin
          if (m_pend) e_ovr = 1; else m_pend = 1;
        end
        if (stop_cmd_in) begin
          m_mode = M_STOP; e_play = 0;
        end else if (!req_in && expired) begin
          m_mode = M_IDLE; e_play = 0; e_stall = 1; m_pend = 0;
        end
        if (req_in) wd_ref = cyc;
      end
      M_STOP: begin
        e_play = 0;
        if (gap_ok) begin
          if (m_pend) begin issue = 1; m_pend = 0; end
          else m_mode = M_IDLE;
        end
      end
      default: ;
    endcase
    if (issue) begin
      last_tick = cyc; e_tick = 1;
      if (!fifo_empty_in) begin
        e_pop = 1; e_a0 = fifo_data0_in; e_a1 = fifo_data1_in;
      end else begin
        e_a0 = '0; e_a1 = '0; e_und = 1;
        if (clr_in) m_cnt = 1;
        else if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endtask

  // One clock: model evaluates at the edge, pulses clear and the FIFO reacts on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    @(negedge clk);
    play_cmd_in = 0; stop_cmd_in = 0; clr_in = 0; req_in = 0;
    if (fifo_pop_out === 1'b1 && fq.size() > 0) fq.delete(0);
    fifo_drive();
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset(); fq.delete(); fifo_drive();
    repeat (3) step();
    total++;
    if (obs_vec !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs_vec); end
    rst_n = 1;
    step();
    total++;
    if (obs_vec !== exp_vec) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs_vec, exp_vec); end
  endtask

  task automatic test_prime_underrun();
    logic [23:0] a0, a1;
    for (int i = 1; i <= 3; i++) fq.push_back({24'h100000 + 24'(i), 24'(i)});
    fifo_drive();
    play_cmd_in = 1; step();
    step();
    total++;
    if ({tick_out, fifo_pop_out, play_out, audio0_out, audio1_out} !== {3'b111, 24'h000001, 24'h100001}) begin
      bad++; $display("FAIL prime_tick got=%b%b%b %h/%h want=111 000001/100001",
                      tick_out, fifo_pop_out, play_out, audio0_out, audio1_out);
    end
    for (int k = 2; k <= 4; k++) begin
      repeat (19) step();
      req_in = 1; step();
      a0 = (k <= 3) ? 24'(k) : 24'h0;
      a1 = (k <= 3) ? 24'h100000 + 24'(k) : 24'h0;
      total++;
      if ({tick_out, fifo_pop_out, audio0_out, audio1_out, underrun_out, underrun_cnt_out} !==
          {1'b1, (k <= 3), a0, a1, (k == 4), CW'((k == 4) ? 1 : 0)}) begin
        bad++; $display("FAIL req_tick_%0d got=%b%b %h/%h und=%b cnt=%0d want pop=%0d %h/%h",
                        k, tick_out, fifo_pop_out, audio0_out, audio1_out, underrun_out,
                        underrun_cnt_out, (k <= 3), a0, a1);
      end
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL prime_model_%0d got=%h want=%h", k, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_pending_overrun();
    int first;
    fq.push_back({24'h100004, 24'h000004});
    fq.push_back({24'h100005, 24'h000005});
    fifo_drive();
    repeat (10) step();
    req_in = 1; step();
    total++;
    if (tick_out !== 1'b1) begin bad++; $display("FAIL pend_first_tick got=%b want=1", tick_out); end
    step(); req_in = 1; step();
    total++;
    if ({tick_out, overrun_out} !== 2'b00) begin bad++; $display("FAIL pend_held got=%b%b want=00", tick_out, overrun_out); end
    step(); req_in = 1; step();
    total++;
    if ({tick_out, overrun_out} !== 2'b01) begin bad++; $display("FAIL pend_drop got=%b%b want=01", tick_out, overrun_out); end
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL pend_model_%0d got=%h want=%h", i, obs_vec, exp_vec); end
      if (tick_out === 1'b1 && first == 0) first = i;
    end
    total++;
    if (first != 4) begin bad++; $display("FAIL pend_served got=cycle %0d want=cycle 4", first); end
    total++;
    if (audio0_out !== 24'h000005) begin bad++; $display("FAIL pend_data got=%h want=000005", audio0_out); end
  endtask

  task automatic test_watchdog();
    int hit;
    repeat (10) step();
    req_in = 1; step();
    hit = 0;
    for (int i = 1; i <= int'(T) + 8; i++) begin
      step();
      if (stall_out === 1'b1) begin hit = i; break; end
    end
    total++;
    if (hit != int'(T)) begin bad++; $display("FAIL wd_expiry got=cycle %0d want=cycle %0d", hit, T); end
    total++;
    if ({stall_out, play_out} !== 2'b10) begin bad++; $display("FAIL wd_state got=%b%b want=10", stall_out, play_out); end
    total++;
    if (obs_vec !== exp_vec) begin bad++; $display("FAIL wd_model got=%h want=%h", obs_vec, exp_vec); end
    repeat (5) step();
    req_in = 1; step(); step();
    total++;
    if (tick_out !== 1'b0) begin bad++; $display("FAIL wd_idle_req got=%b want=0", tick_out); end
  endtask

  task automatic test_stop_pending();
    int first;
    clr_in = 1; step();
    total++;
    if ({underrun_out, overrun_out, stall_out, underrun_cnt_out} !== '0) begin
      bad++; $display("FAIL clr_flags got=%b%b%b cnt=%0d want=0", underrun_out, overrun_out, stall_out, underrun_cnt_out);
    end
    for (int i = 0; i < 3; i++) fq.push_back({24'h20000A + 24'(i), 24'h00000A + 24'(i)});
    fifo_drive();
    play_cmd_in = 1; step(); step();
    total++;
    if ({tick_out, audio0_out} !== {1'b1, 24'h00000A}) begin bad++; $display("FAIL stop_prime got=%b %h want=1 00000a", tick_out, audio0_out); end
    repeat (10) step();
    req_in = 1; step();
    step(); req_in = 1; step();
    stop_cmd_in = 1; step();
    total++;
    if ({play_out, tick_out} !== 2'b00) begin bad++; $display("FAIL stop_play got=%b%b want=00", play_out, tick_out); end
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL stop_model_%0d got=%h want=%h", i, obs_vec, exp_vec); end
      if (tick_out === 1'b1 && first == 0) first = i;
    end
    total++;
    if (first != 5) begin bad++; $display("FAIL stop_pending_tick got=cycle %0d want=cycle 5", first); end
    for (int k = 0; k < 3; k++) begin
      repeat (5) step();
      req_in = 1; step();
      total++;
      if ({tick_out, play_out} !== 2'b00) begin bad++; $display("FAIL stop_idle_req_%0d got=%b%b want=00", k, tick_out, play_out); end
    end
  endtask

  task automatic test_reset_mid();
    fq.delete();
    fq.push_back({24'h300001, 24'h000031});
    fq.push_back({24'h300002, 24'h000032});
    fifo_drive();
    play_cmd_in = 1; step(); step();
    repeat (10) step();
    req_in = 1;
    #4;
    rst_n = 0; model_reset();
    step();
    total++;
    if (obs_vec !== '0) begin bad++; $display("FAIL reset_mid got=%h want=0", obs_vec); end
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if ({tick_out, fifo_pop_out} !== 2'b00 || obs_vec !== exp_vec) begin
        bad++; $display("FAIL reset_mid_after_%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_saturate();
    int want;
    fq.delete();
    fq.push_back({24'h400000, 24'h000077});
    fifo_drive();
    play_cmd_in = 1; step(); step();
    for (int i = 1; i <= NUND; i++) begin
      repeat (9) step();
      req_in = 1; step();
      want = (i > CNT_MAX) ? CNT_MAX : i;
      total++;
      if (tick_out !== 1'b1 || underrun_cnt_out !== CW'(want)) begin
        bad++; $display("FAIL sat_cnt_%0d got=tick %b cnt %0d want=tick 1 cnt %0d", i, tick_out, underrun_cnt_out, want);
      end
    end
    clr_in = 1; step();
    total++;
    if ({underrun_out, overrun_out, stall_out, underrun_cnt_out, play_out} !== {3'b000, CW'(0), 1'b1}) begin
      bad++; $display("FAIL sat_clr got=%b%b%b cnt=%0d play=%b want=000 cnt=0 play=1",
                      underrun_out, overrun_out, stall_out, underrun_cnt_out, play_out);
    end
  endtask

  task automatic test_random();
    int rate;
    rst_n = 0; model_reset(); fq.delete(); fifo_drive();
    step();
    rst_n = 1;
    for (int i = 0; i < 4000; i++) begin
      rate = ((i / 500) % 3 == 0) ? 2 : (((i / 500) % 3 == 1) ? 10 : 120);
      req_in      = ($urandom_range(0, rate) == 0);
      play_cmd_in = ($urandom_range(0, 40) == 0);
      stop_cmd_in = ($urandom_range(0, 90) == 0);
      clr_in      = ($urandom_range(0, 70) == 0);
      if (fq.size() < 4 && $urandom_range(0, 5) == 0) fq.push_back({24'($urandom), 24'($urandom)});
      fifo_drive();
      step();
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL random_%0d got=%h want=%h", i, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_prime_underrun();
    test_pending_overrun();
    test_watchdog();
    test_stop_pending();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
